leaf_inject_control: RTL and testbench

//  Transmit side of the leaf interface: merges outbound stream packets and config-ack packets onto the BFT.

---
 rtl/leaf_inject_control_pkg.sv | 41 ++++
 rtl/leaf_inject_control_fifo2.sv | 51 +++++
 rtl/leaf_inject_control.sv | 109 ++++++++++
 tb/tb_leaf_inject_control.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_inject_control_pkg.sv
// Shared packet layout, port-range constants and grant encoding for the leaf interface.
package leaf_inject_control_pkg;

  localparam int unsigned PACKET_BITS   = 97;
  localparam int unsigned NUM_LEAF_BITS = 6;
  localparam int unsigned NUM_PORT_BITS = 4;
  localparam int unsigned DROP_CNT_BITS = 8;

  // Port map shared with the receive side: 0,1 are config ack, 2..8 stream in, 9.. stream out.
  localparam int unsigned INPUT_PORT_MAX_NUM  = 8;
  localparam int unsigned OUTPUT_PORT_MIN_NUM = 9;
  localparam int unsigned CFG_PORT_MAX_NUM    = 1;

  typedef logic [PACKET_BITS-1:0] packet_t;

  typedef enum logic {
    GNT_STREAM = 1'b0,
    GNT_CFG    = 1'b1
  } gnt_e;

  function automatic logic pkt_vld(input packet_t p);
    return p[PACKET_BITS-1];
  endfunction

  function automatic logic [NUM_LEAF_BITS-1:0] pkt_leaf(input packet_t p);
    return p[PACKET_BITS-2 -: NUM_LEAF_BITS];
  endfunction

  function automatic logic [NUM_PORT_BITS-1:0] pkt_port(input packet_t p);
    return p[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
  endfunction

  function automatic logic stream_legal(input packet_t p);
    return pkt_vld(p) && (pkt_port(p) >= NUM_PORT_BITS'(OUTPUT_PORT_MIN_NUM));
  endfunction

  function automatic logic cfg_legal(input packet_t p);
    return pkt_vld(p) && (pkt_port(p) <= NUM_PORT_BITS'(CFG_PORT_MAX_NUM));
  endfunction

endpackage

// File: rtl/leaf_inject_control_fifo2.sv
// Two-entry packet FIFO; entry 0 is always the head, ready is registered from next-state fill.
module leaf_inject_fifo2
  import leaf_inject_control_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  packet_t din,
  input  logic    pop,
  output packet_t head,
  output logic    nempty,
  output logic    nempty_nxt_c,
  output logic    ready
);

  logic [1:0] count_q, count_d, count_after;
  packet_t    mem_q [2];
  packet_t    mem_d [2];
  logic       ready_q, ready_d;

  always_comb begin
    mem_d       = mem_q;
    count_after = count_q - 2'(pop);
    if (pop) begin
      mem_d[0] = mem_q[1];
    end
    // Caller only pushes when not full, so the write slot is 0 or 1.
    if (push) begin
      mem_d[count_after[0]] = din;
    end
    count_d = count_after + 2'(push);
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
    end
    mem_q <= mem_d;
  end

  assign head         = mem_q[0];
  assign nempty       = (count_q != 2'd0);
  assign nempty_nxt_c = (count_d != 2'd0);
  assign ready        = ready_q;

endmodule

// File: rtl/leaf_inject_control.sv
// Leaf transmit side: filters stream/config-ack packets, round-robins them onto the BFT, honours resend.
module leaf_inject_control
  import leaf_inject_control_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   stream_in,
  input  logic                     stream_in_valid,
  output logic                     stream_in_ready,
  input  logic [PACKET_BITS-1:0]   cfg_in,
  input  logic                     cfg_in_valid,
  output logic                     cfg_in_ready,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  output logic [DROP_CNT_BITS-1:0] drop_count,
  output logic                     busy
);

  localparam int unsigned DROP_SUM_BITS = DROP_CNT_BITS + 1;

  logic    s_xfer, s_push, s_drop, s_pop, s_nempty, s_nempty_nxt;
  logic    c_xfer, c_push, c_drop, c_pop, c_nempty, c_nempty_nxt;
  packet_t s_head, c_head;
  logic    advance;

  packet_t                  dout_q, dout_d;
  gnt_e                     rr_q, rr_d;
  logic [DROP_CNT_BITS-1:0] drop_q, drop_d;
  logic [DROP_SUM_BITS-1:0] drop_sum;
  logic                     busy_q, busy_d;

  // Illegal packets still complete the handshake but never reach a FIFO.
  assign s_xfer = stream_in_valid && stream_in_ready;
  assign c_xfer = cfg_in_valid && cfg_in_ready;
  assign s_push = s_xfer && stream_legal(stream_in);
  assign c_push = c_xfer && cfg_legal(cfg_in);
  assign s_drop = s_xfer && !stream_legal(stream_in);
  assign c_drop = c_xfer && !cfg_legal(cfg_in);

  leaf_inject_fifo2 u_stream_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (s_push),
    .din          (stream_in),
    .pop          (s_pop),
    .head         (s_head),
    .nempty       (s_nempty),
    .nempty_nxt_c (s_nempty_nxt),
    .ready        (stream_in_ready)
  );

  leaf_inject_fifo2 u_cfg_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (c_push),
    .din          (cfg_in),
    .pop          (c_pop),
    .head         (c_head),
    .nempty       (c_nempty),
    .nempty_nxt_c (c_nempty_nxt),
    .ready        (cfg_in_ready)
  );

  assign advance = !pkt_vld(dout_q) || !resend;

  always_comb begin
    dout_d = dout_q;
    rr_d   = rr_q;
    s_pop  = 1'b0;
    c_pop  = 1'b0;
    if (advance) begin
      dout_d = '0;
      // On a tie the source that did not win last time goes next.
      if (s_nempty && (!c_nempty || rr_q == GNT_CFG)) begin
        dout_d = s_head;
        s_pop  = 1'b1;
        rr_d   = GNT_STREAM;
      end else if (c_nempty) begin
        dout_d = c_head;
        c_pop  = 1'b1;
        rr_d   = GNT_CFG;
      end
    end

    drop_sum = {1'b0, drop_q} + DROP_SUM_BITS'(s_drop) + DROP_SUM_BITS'(c_drop);
    drop_d   = drop_sum[DROP_CNT_BITS] ? '1 : drop_sum[DROP_CNT_BITS-1:0];

    busy_d = s_nempty_nxt || c_nempty_nxt || pkt_vld(dout_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      rr_q   <= GNT_CFG;
      drop_q <= '0;
      busy_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
      busy_q <= busy_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign drop_count              = drop_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_leaf_inject_control.sv
// Directed bench for leaf_inject_control; dout is checked in order against a scoreboard queue.
module tb_leaf_inject_control;
  import leaf_inject_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [96:0] stream_in, cfg_in;
  logic        stream_in_valid, cfg_in_valid;
  logic        stream_in_ready, cfg_in_ready;
  logic [96:0] dout;
  logic        resend;
  logic [7:0]  drop_count;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          stream_xfers = 0;
  logic [96:0] exp_q[$];
  logic        adv_prev = 1'b1;

  always #5 clk = ~clk;

  leaf_inject_control dut (
    .clk                     (clk),
    .reset                   (reset),
    .stream_in               (stream_in),
    .stream_in_valid         (stream_in_valid),
    .stream_in_ready         (stream_in_ready),
    .cfg_in                  (cfg_in),
    .cfg_in_valid            (cfg_in_valid),
    .cfg_in_ready            (cfg_in_ready),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .drop_count              (drop_count),
    .busy                    (busy)
  );

  function automatic logic [96:0] mk(input logic v, input logic [5:0] l,
                                     input logic [3:0] p, input logic [85:0] pay);
    return {v, l, p, pay};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_stream(input logic [96:0] p);
    logic r;
    int   n;
    n = 0;
    stream_in = p;
    stream_in_valid = 1'b1;
    do begin
      r = stream_in_ready;
      tick();
      n++;
    end while (!r && n < 64);
    if (!r) chk("stream_handshake_timeout", 0, 1);
    else stream_xfers++;
    stream_in_valid = 1'b0;
  endtask

  task automatic send_cfg(input logic [96:0] p);
    logic r;
    int   n;
    n = 0;
    cfg_in = p;
    cfg_in_valid = 1'b1;
    do begin
      r = cfg_in_ready;
      tick();
      n++;
    end while (!r && n < 64);
    if (!r) chk("cfg_handshake_timeout", 0, 1);
    cfg_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stream_in_valid = 1'b0;
    cfg_in_valid = 1'b0;
    resend = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // A new packet is on dout whenever the previous edge was allowed to advance.
  always @(negedge clk) begin
    if (!reset && dout[96] && adv_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got %0h expected nothing", dout);
      end else begin
        logic [96:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL dout_order: got %0h expected %0h", dout, e);
        end
      end
    end
    adv_prev = !(dout[96] && resend);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [96:0] p1, pp, pq;
    logic [96:0] xs[6];
    int n;
    stream_in = '0;
    cfg_in = '0;
    do_reset();

    // Reset state
    chk("rst_dout", dout, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", stream_in_ready, 1);
    chk("rst_c_ready", cfg_in_ready, 1);

    // 1: single stream packet, two-edge latency
    p1 = mk(1'b1, 6'd5, 4'd9, 86'hA5);
    exp_q.push_back(p1);
    stream_in = p1;
    stream_in_valid = 1'b1;
    tick();
    stream_in_valid = 1'b0;
    chk("t1_dout_edge1", dout, 0);
    tick();
    chk("t1_dout_edge2", dout, p1);
    tick();
    chk("t1_dout_after", dout, 0);
    chk("t1_drop", drop_count, 0);

    // 2: dual traffic alternates S,C,S,C,S,C from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1'b1, 6'd1, 4'd10, 86'(16 + i)));
      exp_q.push_back(mk(1'b1, 6'd2, 4'd0, 86'(32 + i)));
    end
    fork
      for (int i = 0; i < 3; i++) send_stream(mk(1'b1, 6'd1, 4'd10, 86'(16 + i)));
      for (int i = 0; i < 3; i++) send_cfg(mk(1'b1, 6'd2, 4'd0, 86'(32 + i)));
      begin
        n = 0;
        while (!dout[96] && n < 20) begin tick(); n++; end
        for (int i = 0; i < 6; i++) begin
          chk("t2_consecutive", dout[96], 1);
          tick();
        end
        chk("t2_dout_idle", dout, 0);
        chk("t2_busy_fall", busy, 0);
      end
    join

    // 3: resend holds P for 4 cycles, Q follows
    do_reset();
    pp = mk(1'b1, 6'd3, 4'd11, 86'h111);
    pq = mk(1'b1, 6'd3, 4'd12, 86'h222);
    exp_q.push_back(pp);
    exp_q.push_back(pq);
    stream_in = pp;
    stream_in_valid = 1'b1;
    tick();
    stream_in = pq;
    tick();
    stream_in_valid = 1'b0;
    chk("t3_hold0", dout, pp);
    resend = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", dout, pp);
    end
    resend = 1'b0;
    tick();
    chk("t3_next", dout, pq);
    tick();
    chk("t3_idle", dout, 0);

    // 4: illegal packets are dropped and counted, saturating
    do_reset();
    fork
      send_stream(mk(1'b1, 6'd4, 4'd3, 86'h1));
      send_cfg(mk(1'b1, 6'd4, 4'd12, 86'h2));
    join
    send_cfg(mk(1'b0, 6'd4, 4'd0, 86'h3));
    tick();
    chk("t4_drop3", drop_count, 3);
    chk("t4_dout", dout, 0);
    chk("t4_busy", busy, 0);
    for (int i = 0; i < 300; i++) send_stream(mk(1'b1, 6'd1, 4'd4, 86'(i)));
    chk("t4_drop_sat", drop_count, 255);

    // 5: back-pressure fills FIFO, nothing lost or duplicated
    do_reset();
    stream_xfers = 0;
    for (int i = 0; i < 6; i++) begin
      xs[i] = mk(1'b1, 6'd9, 4'(9 + i), 86'(256 + i));
      exp_q.push_back(xs[i]);
    end
    fork
      for (int i = 0; i < 6; i++) send_stream(xs[i]);
      begin
        n = 0;
        while (!dout[96] && n < 20) begin tick(); n++; end
        resend = 1'b1;
        repeat (5) tick();
        #1;
        chk("t5_ready_low", stream_in_ready, 0);
        chk("t5_xfers_while_held", stream_xfers, 3);
        resend = 1'b0;
      end
    join
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    chk("t5_drained", busy, 0);
    chk("t5_all_out", exp_q.size(), 0);

    // 6: reset with both FIFOs full and dout valid
    do_reset();
    resend = 1'b1;
    exp_q.push_back(mk(1'b1, 6'd6, 4'd13, 86'h600));
    fork
      for (int i = 0; i < 3; i++) send_stream(mk(1'b1, 6'd6, 4'd13, 86'(24'h600 + i)));
      for (int i = 0; i < 2; i++) send_cfg(mk(1'b1, 6'd6, 4'd1, 86'(24'h700 + i)));
    join
    chk("t6_full_s", stream_in_ready, 0);
    chk("t6_full_c", cfg_in_ready, 0);
    chk("t6_busy", busy, 1);
    reset = 1'b1;
    resend = 1'b0;
    tick();
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_s_ready", stream_in_ready, 0);
    chk("t6_rst_c_ready", cfg_in_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_rel_s_ready", stream_in_ready, 1);
    chk("t6_rel_c_ready", cfg_in_ready, 1);
    chk("t6_rel_drop", drop_count, 0);
    chk("t6_rel_busy", busy, 0);
    chk("t6_rel_dout", dout, 0);
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
